// File: rtl/is2vid_mode_scheduler.sv
// is2vid_mode_scheduler
//   Mode-bank controller behind the IS2Vid control slave. It completes forwarded
//   mode-register writes with a one-cycle av_write_ack. On each start-of-frame it
//   scans the mode bank for the entry matching the incoming resolution and reports
//   the result on mode_match, with a mode_change pulse when the result changes.
//
//   Optional feature macro: IS2VID_MODE_SCHED_STATS_EN
//     defined     -> nomatch_count counts searches with no match (saturating);
//                    a write to address 9 clears it.
//     not defined -> nomatch_count is tied to 0 and address 9 is a no-op write.
//
//   Handshake: write_trigger is held high by the master until av_write_ack has
//   pulsed; the ack comes exactly two cycles after the trigger is seen in IDLE.
//   sof is a single-cycle pulse with in_* valid in the same cycle; a sof that
//   arrives while the FSM is busy is remembered (newest one only) and served on
//   return to IDLE.
//   dbg_state exposes the FSM state for checkers.
module is2vid_mode_scheduler #(
    parameter int NO_OF_MODES = 4,
    parameter int DIM_WIDTH   = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   write_trigger,
    input  logic [7:0]             av_address,
    input  logic [15:0]            av_writedata,
    output logic                   av_write_ack,
    input  logic                   sof,
    input  logic [DIM_WIDTH-1:0]   in_width,
    input  logic [DIM_WIDTH-1:0]   in_height,
    input  logic                   in_interlaced,
    output logic [NO_OF_MODES-1:0] mode_match,
    output logic                   mode_change,
    output logic                   busy,
    output logic [15:0]            nomatch_count,
    output logic [2:0]             dbg_state
);

    localparam int IW = (NO_OF_MODES > 1) ? $clog2(NO_OF_MODES) : 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WRITE  = 3'd1,
        S_ACK    = 3'd2,
        S_SEARCH = 3'd3,
        S_REPORT = 3'd4
    } state_t;

    state_t r_state;
    state_t w_next;

    // Mode bank
    logic [DIM_WIDTH-1:0]   r_width  [NO_OF_MODES];
    logic [DIM_WIDTH-1:0]   r_height [NO_OF_MODES];
    logic [NO_OF_MODES-1:0] r_valid;
    logic [NO_OF_MODES-1:0] r_intl;
    logic [15:0]            r_bank_sel;

    // Search context: dims under test, and the buffer for a sof seen while busy
    logic [IW-1:0]          r_idx;
    logic [DIM_WIDTH-1:0]   r_sw, r_sh, r_pw, r_ph;
    logic                   r_si, r_pi;
    logic                   r_sof_pending;
    logic [NO_OF_MODES-1:0] r_result;
    logic [NO_OF_MODES-1:0] r_mode_match;
    logic                   r_first;

    logic                   w_entry_hit;
    logic                   w_last;
    logic                   w_change;
    logic                   w_sel_ok;
    logic [IW-1:0]          w_sel;
    logic                   w_start;

    assign w_entry_hit = r_valid[r_idx] && (r_width[r_idx] == r_sw) &&
                         (r_height[r_idx] == r_sh) && (r_intl[r_idx] == r_si);
    assign w_last      = (r_idx == IW'(NO_OF_MODES - 1));
    assign w_change    = (r_result != r_mode_match) || r_first;
    assign w_sel_ok    = (r_bank_sel < 16'(NO_OF_MODES));
    assign w_sel       = r_bank_sel[IW-1:0];
    assign w_start     = (r_state == S_IDLE) && (sof || r_sof_pending);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Next-state and outputs; a new frame outranks a pending write
    always_comb begin
        w_next       = r_state;
        av_write_ack = 1'b0;
        mode_change  = 1'b0;
        mode_match   = r_mode_match;
        busy         = (r_state != S_IDLE);
        dbg_state    = r_state;
        case (r_state)
            S_IDLE: begin
                if (sof || r_sof_pending) w_next = S_SEARCH;
                else if (write_trigger)   w_next = S_WRITE;
            end
            S_WRITE: w_next = S_ACK;
            S_ACK: begin
                av_write_ack = 1'b1;
                w_next       = S_IDLE;
            end
            S_SEARCH: begin
                if (w_entry_hit || w_last) w_next = S_REPORT;
            end
            S_REPORT: begin
                mode_change = w_change;
                if (w_change) mode_match = r_result;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Search sequencing, pending-sof buffer and the reported result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx         <= '0;
            r_sw          <= '0;
            r_sh          <= '0;
            r_si          <= 1'b0;
            r_pw          <= '0;
            r_ph          <= '0;
            r_pi          <= 1'b0;
            r_sof_pending <= 1'b0;
            r_result      <= '0;
            r_mode_match  <= '0;
            r_first       <= 1'b1;
        end else begin
            if (w_start) begin
                r_idx         <= '0;
                r_result      <= '0;
                r_sof_pending <= 1'b0;
                if (sof) begin
                    r_sw <= in_width;
                    r_sh <= in_height;
                    r_si <= in_interlaced;
                end else begin
                    r_sw <= r_pw;
                    r_sh <= r_ph;
                    r_si <= r_pi;
                end
            end else if (sof && (r_state != S_IDLE)) begin
                r_sof_pending <= 1'b1;
                r_pw          <= in_width;
                r_ph          <= in_height;
                r_pi          <= in_interlaced;
            end
            if (r_state == S_SEARCH) begin
                if (w_entry_hit) r_result <= NO_OF_MODES'(1) << r_idx;
                if (!w_last)     r_idx    <= r_idx + IW'(1);
            end
            if (r_state == S_REPORT) begin
                r_first <= 1'b0;
                if (w_change) r_mode_match <= r_result;
            end
        end
    end

    // Register writes; out-of-range bank_sel and unmapped addresses are dropped
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NO_OF_MODES; i++) begin
                r_width[i]  <= '0;
                r_height[i] <= '0;
            end
            r_valid    <= '0;
            r_intl     <= '0;
            r_bank_sel <= '0;
        end else if (r_state == S_WRITE) begin
            case (av_address)
                8'd5: r_bank_sel <= av_writedata;
                8'd6: if (w_sel_ok) r_width[w_sel]  <= DIM_WIDTH'(av_writedata);
                8'd7: if (w_sel_ok) r_height[w_sel] <= DIM_WIDTH'(av_writedata);
                8'd8: if (w_sel_ok) begin
                    r_valid[w_sel] <= av_writedata[0];
                    r_intl[w_sel]  <= av_writedata[1];
                end
                default: ;
            endcase
        end
    end

`ifdef IS2VID_MODE_SCHED_STATS_EN
    logic [15:0] r_nomatch;

    // Saturating count of searches that found no entry; address 9 clears it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_nomatch <= '0;
        end else if ((r_state == S_WRITE) && (av_address == 8'd9)) begin
            r_nomatch <= '0;
        end else if ((r_state == S_REPORT) && (r_result == '0) && (r_nomatch != 16'hFFFF)) begin
            r_nomatch <= r_nomatch + 16'd1;
        end
    end

    assign nomatch_count = r_nomatch;
`else
    assign nomatch_count = 16'd0;
`endif

endmodule

// File: tb/tb_is2vid_mode_scheduler.sv
// Directed bench for is2vid_mode_scheduler (NO_OF_MODES=4, DIM_WIDTH=16).
// Expected mode_match values are queued when a sof is driven and popped by a
// monitor whenever mode_change pulses.
module tb_is2vid_mode_scheduler;
  localparam int N  = 4;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          write_trigger = 1'b0;
  logic [7:0]    av_address = '0;
  logic [15:0]   av_writedata = '0;
  logic          av_write_ack;
  logic          sof = 1'b0;
  logic [DW-1:0] in_width = '0;
  logic [DW-1:0] in_height = '0;
  logic          in_interlaced = 1'b0;
  logic [N-1:0]  mode_match;
  logic          mode_change;
  logic          busy;
  logic [15:0]   nomatch_count;
  logic [2:0]    dbg_state;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int chg_cnt = 0;
  int chg_cyc = -1;
  int exp_nm = 0;
  logic [N-1:0] exp_q[$];

  is2vid_mode_scheduler #(.NO_OF_MODES(N), .DIM_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .write_trigger(write_trigger), .av_address(av_address),
    .av_writedata(av_writedata), .av_write_ack(av_write_ack), .sof(sof),
    .in_width(in_width), .in_height(in_height), .in_interlaced(in_interlaced),
    .mode_match(mode_match), .mode_change(mode_change), .busy(busy),
    .nomatch_count(nomatch_count), .dbg_state(dbg_state)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (!rst && mode_change === 1'b1) begin
      if (exp_q.size() == 0) check("unexpected_mode_change", 32'(mode_match), 32'hDEAD);
      else                   check("mode_match_on_change", 32'(mode_match), 32'(exp_q.pop_front()));
      chg_cnt++;
      chg_cyc = cyc;
    end
  end

  function automatic logic [15:0] exp_nomatch();
`ifdef IS2VID_MODE_SCHED_STATS_EN
    return 16'(exp_nm);
`else
    return 16'd0;
`endif
  endfunction

  // driver: one register write, returns trigger-to-ack latency (-1 on timeout)
  task automatic do_write(input logic [7:0] addr, input logic [15:0] data, output int lat);
    int t0;
    @(posedge clk); #1;
    write_trigger = 1'b1; av_address = addr; av_writedata = data;
    t0 = cyc; lat = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (av_write_ack === 1'b1) begin lat = cyc - t0; break; end
    end
    @(posedge clk); #1;
    write_trigger = 1'b0;
  endtask

  task automatic write_chk(input string tag, input logic [7:0] addr, input logic [15:0] data);
    int lat;
    do_write(addr, data, lat);
    check(tag, 32'(lat), 32'd2);
  endtask

  // driver: one-cycle sof, returns the cycle it was presented in
  task automatic do_sof(input logic [DW-1:0] w, input logic [DW-1:0] h, input logic il, output int t);
    @(posedge clk); #1;
    sof = 1'b1; in_width = w; in_height = h; in_interlaced = il;
    t = cyc;
    @(posedge clk); #1;
    sof = 1'b0;
  endtask

  task automatic wait_change(input int base, output int c);
    c = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); #1;
      if (chg_cnt > base) begin c = chg_cyc; break; end
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(posedge clk);
    #1;
  endtask

  initial begin
    int t, c, base, ack_cyc;

    // reset
    repeat (3) @(posedge clk);
    #1;
    check("reset_mode_match", 32'(mode_match), 32'd0);
    check("reset_mode_change", 32'(mode_change), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_ack", 32'(av_write_ack), 32'd0);
    check("reset_nomatch", 32'(nomatch_count), 32'd0);
    rst = 1'b0;

    // bank setup: entry1 = 640x480 progressive valid, entry3 = 0x50 progressive valid
    write_chk("lat_sel1", 8'd5, 16'd1);
    write_chk("lat_w1", 8'd6, 16'd640);
    write_chk("lat_h1", 8'd7, 16'd480);
    write_chk("lat_f1", 8'd8, 16'h0001);
    write_chk("lat_sel3", 8'd5, 16'd3);
    write_chk("lat_h3", 8'd7, 16'd50);
    write_chk("lat_f3", 8'd8, 16'h0001);
    write_chk("lat_unmapped", 8'd12, 16'h1234);

    // first search: match entry1, pulse at sof+3
    base = chg_cnt;
    exp_q.push_back(4'b0010);
    do_sof(16'd640, 16'd480, 1'b0, t);
    wait_change(base, c);
    check("match_latency", 32'(c), 32'(t + 3));

    // same frame again: no change
    base = chg_cnt;
    do_sof(16'd640, 16'd480, 1'b0, t);
    idle_cycles(10);
    check("repeat_no_change", 32'(chg_cnt), 32'(base));
    check("repeat_match_held", 32'(mode_match), 32'b0010);
    check("repeat_idle", 32'(busy), 32'd0);

    // out-of-range bank_sel: write acked, entry3 untouched (width stays 0)
    write_chk("lat_sel7", 8'd5, 16'd7);
    write_chk("lat_w_dropped", 8'd6, 16'd123);
    base = chg_cnt;
    exp_q.push_back(4'b0000);
    exp_nm++;
    do_sof(16'd123, 16'd50, 1'b0, t);
    wait_change(base, c);
    check("nomatch_latency", 32'(c), 32'(t + N + 1));

    // sof with write_trigger in the same cycle: search first, then the write
    base = chg_cnt;
    exp_q.push_back(4'b0010);
    @(posedge clk); #1;
    sof = 1'b1; in_width = 16'd640; in_height = 16'd480; in_interlaced = 1'b0;
    write_trigger = 1'b1; av_address = 8'd5; av_writedata = 16'd2;
    t = cyc;
    @(posedge clk); #1;
    sof = 1'b0;
    ack_cyc = -1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (av_write_ack === 1'b1) begin ack_cyc = cyc; break; end
    end
    @(posedge clk); #1;
    write_trigger = 1'b0;
    check("collide_change_cyc", 32'(chg_cyc), 32'(t + 3));
    check("collide_change_cnt", 32'(chg_cnt), 32'(base + 1));
    check("collide_ack_cyc", 32'(ack_cyc), 32'(t + 6));

    // sof during WRITE: remembered, search runs after the ack
    base = chg_cnt;
    @(posedge clk); #1;
    write_trigger = 1'b1; av_address = 8'd6; av_writedata = 16'd800;
    t = cyc;
    @(posedge clk); #1;
    exp_q.push_back(4'b0000);
    exp_nm++;
    sof = 1'b1; in_width = 16'd123; in_height = 16'd50; in_interlaced = 1'b0;
    @(posedge clk); #1;
    sof = 1'b0;
    check("pending_ack", 32'(av_write_ack), 32'd1);
    @(posedge clk); #1;
    write_trigger = 1'b0;
    wait_change(base, c);
    check("pending_change_cyc", 32'(c), 32'(t + 8));
    check("nomatch_before_clear", 32'(nomatch_count), 32'(exp_nomatch()));

    // statistics: clear, three unmatched frames, clear again
    write_chk("lat_clear1", 8'd9, 16'd0);
    exp_nm = 0;
    check("nomatch_cleared", 32'(nomatch_count), 32'(exp_nomatch()));
    base = chg_cnt;
    for (int k = 0; k < 3; k++) begin
      do_sof(16'(200 + k), 16'd50, 1'b1, t);
      exp_nm++;
      idle_cycles(8);
    end
    check("nomatch_three", 32'(nomatch_count), 32'(exp_nomatch()));
    check("unmatched_no_change", 32'(chg_cnt), 32'(base));
    write_chk("lat_clear2", 8'd9, 16'd0);
    exp_nm = 0;
    check("nomatch_cleared2", 32'(nomatch_count), 32'(exp_nomatch()));

    // reset during SEARCH: result discarded, no pulse
    base = chg_cnt;
    do_sof(16'd640, 16'd480, 1'b0, t);
    rst = 1'b1;
    #1;
    check("rst_search_match", 32'(mode_match), 32'd0);
    check("rst_search_busy", 32'(busy), 32'd0);
    idle_cycles(2);
    rst = 1'b0;
    idle_cycles(10);
    check("rst_search_no_change", 32'(chg_cnt), 32'(base));
    check("rst_search_idle", 32'(busy), 32'd0);

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
